spatz_vrf: RTL
==============

// Module: spatz_vrf
// PURPOSE
// - Vector register file; serves the VFU's VRF request ports (3 read, 1 write).
// - Each read port owns a one-word operand buffer. It holds rvalid high whenever the
//   buffer matches the requested address, so all of a VFU's operands can be valid together.
// - Misses share NrPhysRead physical read ports through a round-robin arbiter.
// - Writes are accepted every cycle. A write also updates any operand buffer holding that address.
// PARAMETERS
// - NrWords     256  total VRF words (NrVRegs*NrWordsPerVector); power of 2
// - DataWidth   128  word width in bits (N_IPU*ELEN); multiple of 8
// - NrPhysRead  2    physical memory read ports shared by the 3 logical read ports (1..3)
// PORTS
// - clk_i          in   1                  clock
// - rst_i          in   1                  reset, asynchronous, active-high
// - vrf_waddr_i    in   $clog2(NrWords)    write word address
// - vrf_wdata_i    in   DataWidth          write data
// - vrf_we_i       in   1                  write request
// - vrf_wbe_i      in   DataWidth/8        write byte enables
// - vrf_wvalid_o   out  1                  write accepted this cycle
// - vrf_raddr_i    in   3x$clog2(NrWords)  read addresses; [0]=vs2, [1]=vs1, [2]=vd
// - vrf_re_i       in   3                  read requests, held by requester until rvalid
// - vrf_rdata_o    out  3xDataWidth        read data
// - vrf_rvalid_o   out  3                  read data valid for current raddr
// BEHAVIOUR
// - Reset (async, rst_i=1):
//   - buf_valid[2:0]=0 and rr_q=0, so vrf_rvalid_o=0 while reset is asserted.
//   - vrf_wvalid_o=0 (gated by reset); vrf_rdata_o=0.
//   - Memory array is not reset; contents are undefined until written.
// - Write path:
//   - vrf_wvalid_o = vrf_we_i & !rst_i, combinational; the write port never stalls.
//   - At the clock edge, mem[waddr] takes vrf_wdata_i in each byte whose wbe bit is set.
// - Hit (per port p):
//   - hit[p] = buf_valid[p] & (buf_addr[p]==vrf_raddr_i[p]).
//   - vrf_rvalid_o[p] = vrf_re_i[p] & hit[p]; vrf_rdata_o[p] = buf_data[p].
//   - rdata and rvalid come only from registers; there is no comb path from raddr to rdata.
// - Miss: pend[p] = vrf_re_i[p] & !hit[p].
// - Arbitration:
//   - Grant up to NrPhysRead pending ports per cycle, scanning from index rr_q upward mod 3.
//   - rr_q <= (last granted index + 1) mod 3; unchanged if nothing was granted.
// - Fetch:
//   - A granted port loads buf_addr <= raddr, buf_valid <= 1 at the edge.
//   - buf_data <= mem[raddr], merged bytewise with the same-cycle write when we & waddr==raddr.
//   - Miss-to-rvalid latency is 1 cycle when granted immediately.
//   - Worst case with NrPhysRead=1 is 3 cycles.
// - Buffer update by writes:
//   - Every port with buf_valid & buf_addr==waddr merges wdata by wbe at the edge.
//   - Buffers never go stale.
//   - A port fetched in the same cycle gets the merged value through the fetch path.
// - Same-cycle read/write of one address (vd_is_src):
//   - rvalid/rdata show the old value that cycle (read-before-write).
//   - Buffer and memory hold the new value from the next cycle.
// - Buffers stay valid when re drops; re-requesting the same address hits with 0 latency.
// - Two ports missing on the same address are fetched independently; there is no dedupe.
// - Reset mid-fetch: pending grants are discarded; requesters keep re high and re-fetch after release.
// - Address width = $clog2(NrWords); no out-of-range case exists.
// STRUCTURE
// - spatz_pkg provides vreg_addr_t, vreg_data_t, vreg_be_t, NrVRegs and NrWordsPerVector.
//   Local typedef: vrf_buf_t {valid, addr, data}.
// - Sub-module spatz_vrf_fetch_arb:
//   - 3-requester round robin granting NrPhysRead per cycle.
//   - Inputs: pend[2:0], rr_q. Outputs: gnt[2:0], rr_d.
// - Top-level holds the memory array, the 3 operand buffers, the bytewise merge function and the write path.
// TESTING
// - Write/readback:
//   - Write waddr=5, wdata=128'hA5.., wbe='1.
//   - Next cycle re[0]=1, raddr[0]=5 -> rvalid[0]=0 for 1 cycle, then rvalid[0]=1 with 128'hA5...
// - Byte enables:
//   - mem[7]=0; write waddr=7, wdata='1, wbe=16'h000F.
//   - Read 7 -> rdata=128'h0000_..._FFFF_FFFF.
// - Contention (NrPhysRead=2):
//   - re=3'b111 to addresses 1,2,3, all misses, rr_q=0.
//   - Ports 0,1 valid at cycle+1; port 2 valid at cycle+2; rr_q ends at 0.
// - Read-before-write:
//   - Buffer[2] holds addr 9 = X; write addr 9 = Y while re[2]=1.
//   - That cycle rdata[2]=X, rvalid[2]=1; next cycle rdata[2]=Y.
// - Fetch/write collision:
//   - Miss on addr 4 while writing addr 4 with wbe=16'hFF00.
//   - Buffer gets the merged upper bytes; memory matches on a later re-read.
// - Async reset:
//   - Assert rst_i between edges with rvalid=3'b111 -> rvalid=0 immediately.
//   - After release, same requests re-fetch (latency 1-2 cycles).
//   - wvalid=0 while rst_i=1.

Source files
------------

// File: rtl/spatz_pkg.sv
// Shared VRF types and sizing for the Spatz vector unit.
// Provides the default VRF geometry, the word/address/byte-enable types and a
// round-robin index helper used by the VRF fetch arbiter.
package spatz_pkg;

  localparam int unsigned NrVRegs          = 32;
  localparam int unsigned NrWordsPerVector = 8;
  localparam int unsigned NrVrfWords       = NrVRegs * NrWordsPerVector;
  localparam int unsigned VrfDataWidth     = 128;
  localparam int unsigned VrfAddrWidth     = $clog2(NrVrfWords);
  localparam int unsigned VrfBeWidth       = VrfDataWidth / 8;
  localparam int unsigned NrVrfReadPorts   = 3;

  typedef logic [VrfAddrWidth-1:0] vreg_addr_t;
  typedef logic [VrfDataWidth-1:0] vreg_data_t;
  typedef logic [VrfBeWidth-1:0]   vreg_be_t;

  // Index into the three logical read ports (0..2).
  typedef logic [1:0] rr_idx_t;

  // Next port index in the 0 -> 1 -> 2 -> 0 scan order.
  function automatic rr_idx_t rr_next(rr_idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/spatz_vrf_fetch_arb.sv
// Round-robin arbiter granting up to NrPhysRead of the three logical read
// ports' buffer misses per cycle.
// Ports:
//   pend  in  3  port needs a fetch this cycle
//   rr_q  in  2  port index the scan starts from
//   gnt   out 3  ports granted a physical read this cycle
//   rr_d  out 2  next scan start (one past the last grant, else rr_q)
module spatz_vrf_fetch_arb
  import spatz_pkg::*;
#(
  parameter int unsigned NrPhysRead = 2
) (
  input  logic [2:0] pend,
  input  rr_idx_t    rr_q,
  output logic [2:0] gnt,
  output rr_idx_t    rr_d
);

  rr_idx_t    idx;
  logic [1:0] n_gnt;

  // Walk the ports starting at rr_q, granting pending ones until the
  // physical ports are used up.
  always_comb begin
    gnt   = '0;
    rr_d  = rr_q;
    n_gnt = '0;
    idx   = rr_q;
    for (int unsigned k = 0; k < 3; k++) begin
      if (pend[idx] && (n_gnt < 2'(NrPhysRead))) begin
        gnt[idx] = 1'b1;
        n_gnt    = n_gnt + 2'd1;
        rr_d     = rr_next(idx);
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/spatz_vrf.sv
// Spatz vector register file: one write port, three logical read ports
// (vs2, vs1, vd), each backed by a one-word operand buffer. Buffer misses
// share NrPhysRead physical memory reads through a round-robin arbiter.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   vrf_waddr_i/wdata_i/we_i/wbe_i  write request with byte enables
//   vrf_wvalid_o     write accepted this cycle (never stalls)
//   vrf_raddr_i[3]   read addresses, [0]=vs2 [1]=vs1 [2]=vd
//   vrf_re_i[3]      read requests, held until rvalid
//   vrf_rdata_o[3]   operand buffer contents
//   vrf_rvalid_o[3]  buffer holds the requested address
module spatz_vrf
  import spatz_pkg::*;
#(
  parameter  int unsigned NrWords    = NrVrfWords,
  parameter  int unsigned DataWidth  = VrfDataWidth,
  parameter  int unsigned NrPhysRead = 2,
  localparam int unsigned AddrWidth  = $clog2(NrWords),
  localparam int unsigned BeWidth    = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [AddrWidth-1:0]           vrf_waddr_i,
  input  logic [DataWidth-1:0]           vrf_wdata_i,
  input  logic                           vrf_we_i,
  input  logic [BeWidth-1:0]             vrf_wbe_i,
  output logic                           vrf_wvalid_o,
  input  logic [2:0][AddrWidth-1:0]      vrf_raddr_i,
  input  logic [2:0]                     vrf_re_i,
  output logic [2:0][DataWidth-1:0]      vrf_rdata_o,
  output logic [2:0]                     vrf_rvalid_o
);

  typedef struct packed {
    logic                 valid;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } vrf_buf_t;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [DataWidth-1:0] merge_be(logic [DataWidth-1:0] old_w,
                                                    logic [DataWidth-1:0] new_w,
                                                    logic [BeWidth-1:0]   be);
    logic [DataWidth-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BeWidth; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DataWidth-1:0] mem [NrWords];

  vrf_buf_t                  buf_q [3];
  vrf_buf_t                  buf_d [3];
  logic [2:0]                hit;
  logic [2:0]                pend;
  logic [2:0]                gnt;
  rr_idx_t                   rr_q;
  rr_idx_t                   rr_d;
  logic [2:0][DataWidth-1:0] fetch_data;

  // Write port never stalls; only reset blocks it.
  assign vrf_wvalid_o = vrf_we_i & ~rst_i;

  // Memory array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (vrf_wvalid_o) begin
      mem[vrf_waddr_i] <= merge_be(mem[vrf_waddr_i], vrf_wdata_i, vrf_wbe_i);
    end
  end

  // Hit detection and outputs straight from the buffer registers.
  always_comb begin
    hit          = '0;
    pend         = '0;
    vrf_rvalid_o = '0;
    vrf_rdata_o  = '0;
    for (int unsigned p = 0; p < 3; p++) begin
      hit[p]          = buf_q[p].valid && (buf_q[p].addr == vrf_raddr_i[p]);
      pend[p]         = vrf_re_i[p] & ~hit[p];
      vrf_rvalid_o[p] = vrf_re_i[p] & hit[p];
      vrf_rdata_o[p]  = buf_q[p].data;
    end
  end

  spatz_vrf_fetch_arb #(
    .NrPhysRead (NrPhysRead)
  ) i_fetch_arb (
    .pend (pend),
    .rr_q (rr_q),
    .gnt  (gnt),
    .rr_d (rr_d)
  );

  // Fetch data forwards a same-cycle write to the same word so the new
  // buffer content matches what memory will hold after this edge.
  always_comb begin
    fetch_data = '0;
    for (int unsigned p = 0; p < 3; p++) begin
      if (vrf_wvalid_o && (vrf_waddr_i == vrf_raddr_i[p])) begin
        fetch_data[p] = merge_be(mem[vrf_raddr_i[p]], vrf_wdata_i, vrf_wbe_i);
      end else begin
        fetch_data[p] = mem[vrf_raddr_i[p]];
      end
    end
  end

  // Buffer next state: a grant refills the buffer, otherwise a write to the
  // buffered word is merged in so buffers never go stale.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      buf_d[p] = buf_q[p];
      if (gnt[p]) begin
        buf_d[p].valid = 1'b1;
        buf_d[p].addr  = vrf_raddr_i[p];
        buf_d[p].data  = fetch_data[p];
      end else if (vrf_wvalid_o && buf_q[p].valid && (buf_q[p].addr == vrf_waddr_i)) begin
        buf_d[p].data  = merge_be(buf_q[p].data, vrf_wdata_i, vrf_wbe_i);
      end
    end
  end

  // Operand buffers and arbiter pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < 3; p++) begin
        buf_q[p] <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int unsigned p = 0; p < 3; p++) begin
        buf_q[p] <= buf_d[p];
      end
      rr_q <= rr_d;
    end
  end

endmodule
